// File: rtl/clock2_pkg.sv
// Shared types and constants for the clock2 HH:MM:SS clock: set-mode states,
// view-select encodings and the blank segment pattern.
package clock2_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    localparam logic       VIEW_MS   = 1'b0;
    localparam logic       VIEW_HM   = 1'b1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // The mode button walks the states in a fixed ring.
    function automatic state_t next_state(input state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/cnt_bcd.sv
// Two-digit BCD modulo counter covering MIN..MAX. 'en' steps and can carry out;
// 'inc' steps without carry; 'clr' loads CLR_VAL and overrides both.
module cnt_bcd #(
    parameter int MIN     = 0,
    parameter int MAX     = 59,
    parameter int CLR_VAL = MIN
) (
    input  logic       clk,
    input  logic       en,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       ca
);
    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MAX % 10);
    localparam logic [3:0] MIN_T = 4'(MIN / 10);
    localparam logic [3:0] MIN_O = 4'(MIN % 10);
    localparam logic [3:0] CLR_T = 4'(CLR_VAL / 10);
    localparam logic [3:0] CLR_O = 4'(CLR_VAL % 10);

    logic at_max;

    assign at_max = (tens == MAX_T) && (ones == MAX_O);
    assign ca     = en && at_max;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            tens <= CLR_T;
            ones <= CLR_O;
        end else if (en || inc) begin
            if (at_max) begin
                tens <= MIN_T;
                ones <= MIN_O;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/decord_7seg.sv
// BCD digit to active-low 7-segment code {dp,g..a}; dp is always off.
module decord_7seg (
    input  logic [3:0] digit,
    output logic [7:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    end
endmodule

// File: rtl/clock2.sv
// HH:MM:SS clock with 12/24-hour mode, set-mode FSM and HH:MM / MM:SS view.
// Defining CLOCK2_BLINK_EN blinks the field being set while it is in view.
module clock2
    import clock2_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int HOUR_MODE = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    input  logic       sw,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic       pm,
    output logic [1:0] state
);
    localparam bit H12   = (HOUR_MODE == 12);
    localparam int H_MIN = H12 ? 1 : 0;
    localparam int H_MAX = H12 ? 12 : 23;
    localparam int H_CLR = H12 ? 12 : 0;
    localparam int PW    = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    generate
        if (HOUR_MODE != 12 && HOUR_MODE != 24) begin : g_bad_hour_mode
            $error("clock2: HOUR_MODE must be 12 or 24");
        end
        if (CLK_FREQ < 4 || (CLK_FREQ % 2) != 0) begin : g_bad_clk_freq
            $error("clock2: CLK_FREQ must be even and at least 4");
        end
    endgenerate

    state_t        state_q, state_n;
    logic [PW-1:0] presc;
    logic          tick, mode_evt, inc_evt, run_tick, leave_set, fld_clr;
    logic          sec_inc, min_inc, hour_inc;
    logic [3:0]    sec_t, sec_o, min_t, min_o, hour_t, hour_o;
    logic          sec_ca, min_ca, hour_ca_unused;
    logic          pm_q;
    logic [3:0]    dig [4];
    logic [7:0]    seg [4];
    logic          blank_hi, blank_lo;

    // Event priority: clr > mode > inc > tick; rst is folded in at each register.
    assign mode_evt  = btn_mode && !btn_clr;
    assign inc_evt   = btn_inc && !btn_clr && !btn_mode;
    assign run_tick  = tick && (state_q == RUN) && !btn_clr && !btn_mode && !btn_inc;
    assign leave_set = mode_evt && (state_q == SET_SEC);
    assign fld_clr   = rst || btn_clr;
    assign sec_inc   = inc_evt && (state_q == SET_SEC);
    assign min_inc   = inc_evt && (state_q == SET_MIN);
    assign hour_inc  = inc_evt && (state_q == SET_HOUR);

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst || btn_clr || leave_set || tick) presc <= '0;
        else                                      presc <= presc + PW'(1);
    end

    always_comb begin
        state_n = state_q;
        if (mode_evt) state_n = next_state(state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_n;
    end

    assign state = state_q;

    cnt_bcd #(.MIN(0), .MAX(59), .CLR_VAL(0)) u_sec (
        .clk(clk), .en(run_tick), .inc(sec_inc), .clr(fld_clr),
        .tens(sec_t), .ones(sec_o), .ca(sec_ca)
    );

    cnt_bcd #(.MIN(0), .MAX(59), .CLR_VAL(0)) u_min (
        .clk(clk), .en(sec_ca), .inc(min_inc), .clr(fld_clr),
        .tens(min_t), .ones(min_o), .ca(min_ca)
    );

    cnt_bcd #(.MIN(H_MIN), .MAX(H_MAX), .CLR_VAL(H_CLR)) u_hour (
        .clk(clk), .en(min_ca), .inc(hour_inc), .clr(fld_clr),
        .tens(hour_t), .ones(hour_o), .ca(hour_ca_unused)
    );

    // pm flips whenever the 12h hour steps out of 11, by run carry or by set.
    always_ff @(posedge clk) begin
        if (rst || btn_clr)
            pm_q <= 1'b0;
        else if (H12 && hour_t == 4'd1 && hour_o == 4'd1 && (min_ca || hour_inc))
            pm_q <= ~pm_q;
    end

    assign pm = pm_q;

    always_comb begin
        // NOTE: every element gets a default first so no path through this block infers a latch.
        dig[3] = min_t;
        dig[2] = min_o;
        dig[1] = sec_t;
        dig[0] = sec_o;
        if (rst) begin
            dig[3] = (sw == VIEW_HM) ? 4'(H_CLR / 10) : 4'd0;
            dig[2] = (sw == VIEW_HM) ? 4'(H_CLR % 10) : 4'd0;
            dig[1] = 4'd0;
            dig[0] = 4'd0;
        end else if (sw == VIEW_HM) begin
            dig[3] = hour_t;
            dig[2] = hour_o;
            dig[1] = min_t;
            dig[0] = min_o;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dec
        decord_7seg u_dec (.digit(dig[g]), .seg(seg[g]));
    end

`ifdef CLOCK2_BLINK_EN
    localparam int HALF = CLK_FREQ / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_ph;

    always_ff @(posedge clk) begin
        if (rst || state_n != state_q) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign blank_hi = !rst && blink_ph &&
                      ((state_q == SET_HOUR && sw == VIEW_HM) || (state_q == SET_MIN && sw == VIEW_MS));
    assign blank_lo = !rst && blink_ph &&
                      ((state_q == SET_MIN && sw == VIEW_HM) || (state_q == SET_SEC && sw == VIEW_MS));
`else
    assign blank_hi = 1'b0;
    assign blank_lo = 1'b0;
`endif

    // NOTE: the display flops need no reset branch; while rst is high the digit mux feeds them the reset time.
    always_ff @(posedge clk) begin
        hex3 <= blank_hi ? SEG_BLANK : seg[3];
        hex2 <= blank_hi ? SEG_BLANK : seg[2];
        hex1 <= blank_lo ? SEG_BLANK : seg[1];
        hex0 <= blank_lo ? SEG_BLANK : seg[0];
    end

endmodule

// File: doc/clock2.md
# clock2

Parametrised HH:MM:SS digital clock driving four 7-segment digits, the next generation of the MM:SS board clock. Adds an hour field with 12/24-hour mode, a mode-button set-mode state machine with per-field increment, and a selectable HH:MM / MM:SS view. It takes debounced single-cycle button pulses from the existing `btn_in` stage and drives the board HEX displays directly.

## Interface

**Parameters**
- `CLK_FREQ`, default 50_000_000: `clk` cycles per second; must be ≥ 4 and even.
- `HOUR_MODE`, default 24: 24 gives hours 00..23; 12 gives hours 12,01..11 plus the `pm` flag. Any other value is illegal and is caught by an elaboration assertion.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_mode` in 1: one-cycle pulse; advances the set-mode FSM.
- `btn_inc` in 1: one-cycle pulse; increments the field being set.
- `btn_clr` in 1: one-cycle pulse; clears the time.
- `sw` in 1: view select. 0 shows MM:SS; 1 shows HH:MM.
- `hex0`..`hex3` out 8 each: active-low segments {dp,g..a}. `hex0` is the rightmost digit. dp is always off (1).
- `pm` out 1: PM flag. Always 0 when `HOUR_MODE`=24.
- `state` out 2: current FSM state, for LEDs.

## Operation

- **Prescaler**
  - Counts 0..`CLK_FREQ`-1.
  - `tick` is asserted for one cycle when the count equals `CLK_FREQ`-1; the prescaler then wraps to 0.
  - It is cleared by `rst`, by `btn_clr`, and on the SET_SEC→RUN transition, so the first second after setting is a full second.
- **Fields**
  - Each field is a BCD pair: sec 00..59, min 00..59, hour per `HOUR_MODE`.
  - In RUN, `tick` advances sec.
  - sec 59→00 carries to min; min 59→00 with a sec carry carries to hour, all in the same cycle.
  - 24h: hour 23→00.
  - 12h: hour 12→01. Hour 11→12 toggles `pm`.
- **FSM states** (encoded in the package): RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
  - `btn_mode` moves RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - In any SET state, `tick` does not advance the time.
  - `btn_inc` in SET_x increments that field only, modulo its range, with no carry. In 12h mode, SET_HOUR 11→12 toggles `pm`.
  - `btn_inc` in RUN is ignored.
- **Clear**
  - `btn_clr` in any state sets the time to 00:00:00 (12h mode: 12:00:00 with `pm`=0) and clears the prescaler.
  - The FSM state is unchanged.
- **Priority for simultaneous pulses** (highest first): `rst` > `btn_clr` > `btn_mode` > `btn_inc` > `tick`. A lower-priority event in the same cycle is dropped. The exception is a `tick` arriving on the cycle of SET_SEC→RUN: it is dropped and the prescaler restarts.
- **Display mux**
  - `sw`=0: {`hex3`,`hex2`,`hex1`,`hex0`} = min tens, min ones, sec tens, sec ones.
  - `sw`=1: {`hex3`,`hex2`,`hex1`,`hex0`} = hour tens, hour ones, min tens, min ones.
  - A tens digit of 0 is shown as "0"; there is no leading-zero blanking.
  - Segment codes follow the existing `decord_7seg` table ("0" = 8'hC0).

## Timing

- **Reset values:**
  - 24h: time 00:00:00, `state`=RUN, `pm`=0, all `hex` = 8'hC0.
  - 12h: hour 12, so `hex3`/`hex2` show 8'hF9 / 8'hA4 when `sw`=1.
- **Latency:**
  - Field registers update on the edge that samples the pulse or `tick`.
  - `hex*` are registered and follow the field registers by 1 cycle.
  - `state` and `pm` change on the same edge as the fields.
- **Reset mid-operation:** `rst` overrides everything on the sampling edge. A button pulse in the reset cycle is lost.
- **`sw` change:** the display reflects the new view 1 cycle after `sw` is sampled.

## Configuration

- Macro: `CLOCK2_BLINK_EN`.
- **When defined:**
  - A blink phase register toggles every `CLK_FREQ`/2 cycles. It is reset to 0 and also cleared on every FSM transition.
  - In a SET state, while the phase is 1, both digits of the field being set are driven 8'hFF (blank), if that field is in the current view.
  - Digits not in view are unaffected.
- **When undefined:** no blink logic is built and set-mode digits are always shown.

## Structure

- `clock2_pkg` holds:
  - the `state_t` enum (RUN, SET_HOUR, SET_MIN, SET_SEC);
  - the view-select constants `VIEW_MS`=0 and `VIEW_HM`=1;
  - the segment constant `SEG_BLANK`=8'hFF.
- Sub-module `cnt_bcd`: a parametrised BCD modulo counter. It has ports `en`, `inc`, `clr`, and outputs `tens`, `ones`, `ca`. Parameters `MAX` and `MIN` set the range.
- `clock2` instantiates `cnt_bcd` three times (sec, min, hour) plus four existing `decord_7seg`. The hour instance uses `MIN`=1, `MAX`=12 in 12h mode.

## Test plan

All scenarios use `CLK_FREQ`=4.

1. **Reset:** hold `rst` 2 cycles with `sw`=0 → all `hex`=8'hC0, `state`=0, `pm`=0.
2. **Run and carry:** run 240 cycles after reset → MM:SS = 01:00. Continue to 3600 ticks with `sw`=1 → HH:MM = 01:00.
3. **24h wrap:** set 23:59:59 via mode/inc presses, return to RUN, wait 4 cycles → 00:00:00.
4. **12h wrap:** with `HOUR_MODE`=12, set 11:59:59 with `pm`=0 and run 1 tick → 12:00:00 with `pm`=1.
5. **Clear priority:** in SET_MIN at 07 min, assert `btn_clr` and `btn_inc` together → time 00:00:00, `state` stays 2. Then `btn_inc` alone → min 01.
6. **Blink** (`CLOCK2_BLINK_EN` defined): in SET_MIN with `sw`=0, `hex3`/`hex2` alternate 8'hFF and the digit every 2 cycles while `hex1`/`hex0` stay steady. With `sw`=1 the blinking moves to `hex1`/`hex0`. Without the macro, nothing blinks.
